// File: rtl/uart_wb_master_bridge.sv
// UART byte-stream to Wishbone classic initiator.
// Decodes write (0x01 + addr + data) and read (0x02 + addr) frames, runs one
// single Wishbone cycle, then returns a status byte (plus read data on success).
module uart_wb_master_bridge #(
  parameter int BUS_TIMEOUT   = 1024,
  parameter int FRAME_TIMEOUT = 65536
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        rx_overrun_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i
);

  localparam int BT_W = $clog2(BUS_TIMEOUT + 1);
  localparam int FT_W = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [BT_W-1:0] BT_LAST = BT_W'(BUS_TIMEOUT - 1);
  localparam logic [FT_W-1:0] FT_LAST = FT_W'(FRAME_TIMEOUT - 1);

  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] ST_ACK     = 8'h4B;
  localparam logic [7:0] ST_ERR     = 8'hEE;
  localparam logic [7:0] ST_RTY     = 8'hED;
  localparam logic [7:0] ST_TIMEOUT = 8'hEF;
  localparam logic [7:0] ST_BADCMD  = 8'hE1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_BUS  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t          state_r;
  logic [1:0]      cnt_r;
  logic            we_r;
  logic [31:0]     adr_sh_r;
  logic [31:0]     dat_sh_r;
  logic [31:0]     rdata_r;
  logic [7:0]      status_r;
  logic            read_ok_r;
  logic [2:0]      idx_r;
  logic [FT_W-1:0] frame_tmr_r;
  logic [BT_W-1:0] bus_tmr_r;

  logic            bus_done_s;
  logic [7:0]      bus_status_s;
  logic [2:0]      resp_last_s;

  // Response byte selector: status first, then read data MSB first.
  function automatic logic [7:0] resp_byte(input logic [2:0] idx,
                                           input logic [7:0] status,
                                           input logic [31:0] rdata);
    case (idx)
      3'd0:    resp_byte = status;
      3'd1:    resp_byte = rdata[31:24];
      3'd2:    resp_byte = rdata[23:16];
      3'd3:    resp_byte = rdata[15:8];
      3'd4:    resp_byte = rdata[7:0];
      default: resp_byte = 8'h00;
    endcase
  endfunction

  assign wbm_cti_o   = 3'b000;
  assign wbm_bte_o   = 2'b00;
  assign resp_last_s = read_ok_r ? 3'd4 : 3'd0;

  // Bus termination decode with err > rty > ack > timeout priority.
  always_comb begin
    bus_done_s   = 1'b0;
    bus_status_s = 8'h00;
    if (wbm_err_i) begin
      bus_done_s   = 1'b1;
      bus_status_s = ST_ERR;
    end else if (wbm_rty_i) begin
      bus_done_s   = 1'b1;
      bus_status_s = ST_RTY;
    end else if (wbm_ack_i) begin
      bus_done_s   = 1'b1;
      bus_status_s = ST_ACK;
    end else if (bus_tmr_r == BT_LAST) begin
      bus_done_s   = 1'b1;
      bus_status_s = ST_TIMEOUT;
    end else begin
      bus_done_s   = 1'b0;
      bus_status_s = 8'h00;
    end
  end

  // Frame decoder, bus cycle control and response sequencer.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_r      <= S_IDLE;
      cnt_r        <= 2'd0;
      we_r         <= 1'b0;
      adr_sh_r     <= 32'h0000_0000;
      dat_sh_r     <= 32'h0000_0000;
      rdata_r      <= 32'h0000_0000;
      status_r     <= 8'h00;
      read_ok_r    <= 1'b0;
      idx_r        <= 3'd0;
      frame_tmr_r  <= '0;
      bus_tmr_r    <= '0;
      tx_data_o    <= 8'h00;
      tx_valid_o   <= 1'b0;
      rx_overrun_o <= 1'b0;
      wbm_adr_o    <= 32'h0000_0000;
      wbm_dat_o    <= 32'h0000_0000;
      wbm_sel_o    <= 4'h0;
      wbm_we_o     <= 1'b0;
      wbm_cyc_o    <= 1'b0;
      wbm_stb_o    <= 1'b0;
    end else begin
      rx_overrun_o <= 1'b0;
      case (state_r)
        S_IDLE: begin
          frame_tmr_r <= '0;
          cnt_r       <= 2'd0;
          if (rx_valid_i) begin
            case (rx_data_i)
              CMD_WRITE: begin
                we_r    <= 1'b1;
                state_r <= S_ADDR;
              end
              CMD_READ: begin
                we_r    <= 1'b0;
                state_r <= S_ADDR;
              end
              default: begin
                status_r   <= ST_BADCMD;
                read_ok_r  <= 1'b0;
                idx_r      <= 3'd0;
                tx_data_o  <= ST_BADCMD;
                tx_valid_o <= 1'b1;
                state_r    <= S_RESP;
              end
            endcase
          end
        end
        S_ADDR: begin
          if (rx_valid_i) begin
            adr_sh_r    <= {adr_sh_r[23:0], rx_data_i};
            frame_tmr_r <= '0;
            cnt_r       <= cnt_r + 2'd1;
            if (cnt_r == 2'd3) begin
              if (we_r) begin
                state_r <= S_DATA;
              end else begin
                wbm_adr_o <= {adr_sh_r[23:0], rx_data_i};
                wbm_dat_o <= 32'h0000_0000;
                wbm_we_o  <= 1'b0;
                wbm_sel_o <= 4'hF;
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                bus_tmr_r <= '0;
                state_r   <= S_BUS;
              end
            end
          end else if (frame_tmr_r == FT_LAST) begin
            frame_tmr_r <= '0;
            state_r     <= S_IDLE;
          end else begin
            frame_tmr_r <= frame_tmr_r + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_valid_i) begin
            dat_sh_r    <= {dat_sh_r[23:0], rx_data_i};
            frame_tmr_r <= '0;
            cnt_r       <= cnt_r + 2'd1;
            if (cnt_r == 2'd3) begin
              wbm_adr_o <= adr_sh_r;
              wbm_dat_o <= {dat_sh_r[23:0], rx_data_i};
              wbm_we_o  <= 1'b1;
              wbm_sel_o <= 4'hF;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              bus_tmr_r <= '0;
              state_r   <= S_BUS;
            end
          end else if (frame_tmr_r == FT_LAST) begin
            frame_tmr_r <= '0;
            state_r     <= S_IDLE;
          end else begin
            frame_tmr_r <= frame_tmr_r + 1'b1;
          end
        end
        S_BUS: begin
          rx_overrun_o <= rx_valid_i;
          if (bus_done_s) begin
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_sel_o  <= 4'h0;
            wbm_we_o   <= 1'b0;
            status_r   <= bus_status_s;
            read_ok_r  <= (bus_status_s == ST_ACK) && !we_r;
            rdata_r    <= wbm_dat_i;
            idx_r      <= 3'd0;
            tx_data_o  <= bus_status_s;
            tx_valid_o <= 1'b1;
            state_r    <= S_RESP;
          end else begin
            bus_tmr_r <= bus_tmr_r + 1'b1;
          end
        end
        S_RESP: begin
          rx_overrun_o <= rx_valid_i;
          if (tx_valid_o && tx_ready_i) begin
            if (idx_r == resp_last_s) begin
              tx_valid_o <= 1'b0;
              state_r    <= S_IDLE;
            end else begin
              idx_r     <= idx_r + 3'd1;
              tx_data_o <= resp_byte(idx_r + 3'd1, status_r, rdata_r);
            end
          end
        end
        default: begin
          state_r    <= S_IDLE;
          tx_valid_o <= 1'b0;
          wbm_cyc_o  <= 1'b0;
          wbm_stb_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_master_bridge.sv
// Directed bench for uart_wb_master_bridge with a tx-byte scoreboard.
module tb_uart_wb_master_bridge;

  localparam int BT = 16;
  localparam int FT = 32;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        rx_overrun;
  logic [31:0] wbm_adr, wbm_dat_o, wbm_dat_i = 32'h0;
  logic [3:0]  wbm_sel;
  logic        wbm_we, wbm_cyc, wbm_stb;
  logic [2:0]  wbm_cti;
  logic [1:0]  wbm_bte;
  logic        wbm_ack = 1'b0, wbm_err = 1'b0, wbm_rty = 1'b0;

  int          n_vec = 0;
  int          n_err = 0;
  int          ovr_cnt = 0;
  int          ready_mode = 0;  // 0: always ready, 1: toggle, 2: held low
  logic [7:0]  sb[$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_b = 8'h00;

  uart_wb_master_bridge #(.BUS_TIMEOUT(BT), .FRAME_TIMEOUT(FT)) dut (
    .clk_i(clk), .nrst_i(nrst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .rx_overrun_o(rx_overrun),
    .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel),
    .wbm_we_o(wbm_we), .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb),
    .wbm_cti_o(wbm_cti), .wbm_bte_o(wbm_bte),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err), .wbm_rty_i(wbm_rty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_read(input logic [31:0] a);
    send(8'h02);
    for (int i = 3; i >= 0; i--) send(a[i*8 +: 8]);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send(8'h01);
    for (int i = 3; i >= 0; i--) send(a[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) send(d[i*8 +: 8]);
  endtask

  task automatic push_read_resp(input logic [31:0] d);
    sb.push_back(8'h4B);
    for (int i = 3; i >= 0; i--) sb.push_back(d[i*8 +: 8]);
  endtask

  // Slave model: kind 0 ack, 1 err, 2 rty, 3 err+ack, 4 silent (timeout)
  task automatic bus_respond(input logic [31:0] e_adr, input logic [31:0] e_dat,
                             input logic e_we, input int delay, input int kind,
                             input logic [31:0] rdata);
    int n;
    n = 0;
    while (!wbm_cyc && n < 20) begin
      tick();
      n++;
    end
    check("cyc_latency", n, 0);
    check("wb_adr", wbm_adr, e_adr);
    check("wb_ctl", {wbm_stb, wbm_we, wbm_sel, wbm_cti, wbm_bte},
          {1'b1, e_we, 4'hF, 3'b000, 2'b00});
    if (e_we) check("wb_dat", wbm_dat_o, e_dat);
    if (kind == 4) begin
      n = 0;
      while (wbm_cyc && n < 100) begin
        n++;
        tick();
      end
      check("bus_timeout_len", n, BT);
    end else begin
      repeat (delay) tick();
      check("cyc_held", {wbm_cyc, wbm_stb, (wbm_adr == e_adr)}, 3'b111);
      wbm_dat_i = rdata;
      wbm_ack   = (kind == 0) || (kind == 3);
      wbm_err   = (kind == 1) || (kind == 3);
      wbm_rty   = (kind == 2);
      tick();
      wbm_ack   = 1'b0;
      wbm_err   = 1'b0;
      wbm_rty   = 1'b0;
      wbm_dat_i = 32'h0;
      check("cyc_drop", {wbm_cyc, wbm_stb}, 2'b00);
    end
    check("tx_valid_latency", tx_valid, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() > 0 || tx_valid) && n < 300) begin
      tick();
      n++;
    end
    check("drain_queue", sb.size(), 0);
    check("drain_tx_valid", tx_valid, 1'b0);
  endtask

  // tx_ready pattern generator
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Transmit monitor: pop scoreboard on each handshake, check hold stability
  always @(negedge clk) begin
    if (nrst) begin
      if (prev_stall && tx_valid) check("tx_hold", tx_data, prev_b);
      if (tx_valid && tx_ready) begin
        n_vec++;
        assert (sb.size() > 0) else begin
          n_err++;
          $error("FAIL tx_unexpected observed=%h expected=none", tx_data);
        end
        if (sb.size() > 0) check("tx_byte", tx_data, sb.pop_front());
      end
      prev_stall = tx_valid && !tx_ready;
      prev_b     = tx_data;
      if (rx_overrun) ovr_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovr0;
    logic no_cyc;
    repeat (3) tick();
    check("reset_ctl", {wbm_cyc, wbm_stb, wbm_we, wbm_sel, tx_valid, rx_overrun}, 9'd0);
    check("reset_adr", wbm_adr, 32'h0);
    check("reset_tx", tx_data, 8'h00);
    nrst = 1'b1;
    repeat (2) tick();

    // Write, ack after 3 cycles
    send_write(32'h0000_1000, 32'hDEAD_BEEF);
    sb.push_back(8'h4B);
    bus_respond(32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 3, 0, 32'h0);
    drain();

    // Read with tx_ready toggling
    ready_mode = 1;
    send_read(32'h0000_2004);
    push_read_resp(32'h1234_5678);
    bus_respond(32'h0000_2004, 32'h0, 1'b0, 1, 0, 32'h1234_5678);
    drain();
    ready_mode = 0;

    // Silent slave: timeout
    send_read(32'h0000_3008);
    sb.push_back(8'hEF);
    bus_respond(32'h0000_3008, 32'h0, 1'b0, 0, 4, 32'h0);
    drain();

    // err and ack together, then rty alone
    send_write(32'h0000_4003, 32'h0102_0304);
    sb.push_back(8'hEE);
    bus_respond(32'h0000_4003, 32'h0102_0304, 1'b1, 2, 3, 32'h0);
    drain();
    send_write(32'h8000_0001, 32'hA5A5_5A5A);
    sb.push_back(8'hED);
    bus_respond(32'h8000_0001, 32'hA5A5_5A5A, 1'b1, 0, 2, 32'h0);
    drain();

    // Bad command byte
    send(8'h7F);
    sb.push_back(8'hE1);
    check("badcmd_tx_valid", tx_valid, 1'b1);
    drain();

    // Partial frame abandoned past the frame timeout
    send(8'h01);
    send(8'h00);
    send(8'h00);
    no_cyc = 1'b1;
    for (int i = 0; i < FT + 8; i++) begin
      if (wbm_cyc || tx_valid) no_cyc = 1'b0;
      tick();
    end
    check("frame_timeout_quiet", no_cyc, 1'b1);
    send_read(32'h0000_3000);
    push_read_resp(32'h0BAD_F00D);
    bus_respond(32'h0000_3000, 32'h0, 1'b0, 0, 0, 32'h0BAD_F00D);
    drain();

    // Bytes during RESP are dropped and flagged
    ready_mode = 2;
    send_read(32'h0000_0040);
    push_read_resp(32'hCAFE_F00D);
    bus_respond(32'h0000_0040, 32'h0, 1'b0, 0, 0, 32'hCAFE_F00D);
    ovr0 = ovr_cnt;
    send(8'h01);
    tick();
    send(8'h02);
    send(8'h7F);
    repeat (2) tick();
    check("overrun_pulses", ovr_cnt - ovr0, 3);
    ready_mode = 0;
    drain();

    // Reset while cyc high
    send_read(32'h0000_2004);
    tick();
    check("pre_reset_cyc", wbm_cyc, 1'b1);
    nrst = 1'b0;
    #1;
    check("reset_mid_bus", {wbm_cyc, wbm_stb, tx_valid}, 3'b000);
    tick();
    nrst = 1'b1;
    tick();

    // Reset mid-RESP (stalled, nothing expected)
    ready_mode = 2;
    send_read(32'h0000_5000);
    bus_respond(32'h0000_5000, 32'h0, 1'b0, 0, 0, 32'h5555_AAAA);
    tick();
    nrst = 1'b0;
    #1;
    check("reset_mid_resp", {wbm_cyc, wbm_stb, tx_valid}, 3'b000);
    tick();
    nrst = 1'b1;
    ready_mode = 0;
    tick();

    // Fresh read after reset
    send_read(32'h0000_6004);
    push_read_resp(32'h8765_4321);
    bus_respond(32'h0000_6004, 32'h0, 1'b0, 2, 0, 32'h8765_4321);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
